// File: rtl/elevator_shaft_model_pkg.sv
// Shared definitions for the elevator shaft plant: actuator command encodings,
// door FSM states and fault cause codes, plus the fault priority encoder.
package elevator_shaft_model_pkg;

    typedef enum logic [1:0] {
        ENG_STOP = 2'b00,
        ENG_UP   = 2'b01,
        ENG_DOWN = 2'b10,
        ENG_ILL  = 2'b11
    } engine_cmd_e;

    typedef enum logic [1:0] {
        DOOR_HOLD  = 2'b00,
        DOOR_OPEN  = 2'b01,
        DOOR_CLOSE = 2'b10,
        DOOR_ILL   = 2'b11
    } door_cmd_e;

    typedef enum logic [1:0] {
        DS_CLOSED,
        DS_OPENING,
        DS_OPEN,
        DS_CLOSING
    } door_state_e;

    localparam logic [2:0] FLT_NONE        = 3'd0;
    localparam logic [2:0] FLT_MOVE_DOOR   = 3'd1;
    localparam logic [2:0] FLT_OVERTRAVEL  = 3'd2;
    localparam logic [2:0] FLT_DOOR_MOVING = 3'd3;
    localparam logic [2:0] FLT_ILLEGAL     = 3'd4;

    // Lowest-numbered cause wins when several occur in the same cycle.
    function automatic logic [2:0] first_fault(input logic f_move_door,
                                               input logic f_overtravel,
                                               input logic f_door_moving,
                                               input logic f_illegal);
        if (f_move_door)        return FLT_MOVE_DOOR;
        else if (f_overtravel)  return FLT_OVERTRAVEL;
        else if (f_door_moving) return FLT_DOOR_MOVING;
        else if (f_illegal)     return FLT_ILLEGAL;
        else                    return FLT_NONE;
    endfunction

endpackage

// File: rtl/elevator_shaft_model_door.sv
// Door plant: door FSM, stroke counter and obstruction handling.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_cmd         door command, already sanitised by the top (illegal/refused -> HOLD)
//   i_obstruct    object in doorway
//   o_closed      door fully closed
//   o_open        door fully open
//   o_sensor      obstruction seen during a close stroke / the reopen it caused
module elevator_door_model
    import elevator_shaft_model_pkg::*;
#(
    parameter int unsigned DOOR_TICKS = 3
) (
    input  logic      clk,
    input  logic      rst,
    input  door_cmd_e i_cmd,
    input  logic      i_obstruct,
    output logic      o_closed,
    output logic      o_open,
    output logic      o_sensor
);

    localparam int unsigned SW = $clog2(DOOR_TICKS + 1);
    localparam logic [SW-1:0] STROKE_FULL = SW'(DOOR_TICKS);

    door_state_e   r_state;
    logic [SW-1:0] r_stroke;
    logic          r_closed;
    logic          r_open;
    logic          r_sensor;

    door_state_e   w_state_nxt;
    logic [SW-1:0] w_stroke_nxt;
    logic          w_sensor_nxt;
    logic          w_open_step;
    logic          w_close_step;

    always_comb begin
        w_state_nxt  = r_state;
        w_stroke_nxt = r_stroke;
        w_open_step  = 1'b0;
        w_close_step = 1'b0;
        // Sensor stays up while the obstruction persists through the forced reopen.
        w_sensor_nxt = i_obstruct &&
                       (r_state == DS_CLOSING || (r_state == DS_OPENING && r_sensor));

        case (r_state)
            DS_CLOSED:  w_open_step = (i_cmd == DOOR_OPEN);
            DS_OPENING: begin
                w_open_step  = (i_cmd == DOOR_OPEN);
                w_close_step = (i_cmd == DOOR_CLOSE);
            end
            DS_OPEN:    w_close_step = (i_cmd == DOOR_CLOSE);
            DS_CLOSING: begin
                // Obstruction overrides the close command and reverses the stroke.
                w_open_step  = i_obstruct || (i_cmd == DOOR_OPEN);
                w_close_step = !i_obstruct && (i_cmd == DOOR_CLOSE);
            end
            default: ;
        endcase

        if (w_open_step) begin
            w_stroke_nxt = r_stroke + SW'(1);
            w_state_nxt  = (r_stroke + SW'(1) == STROKE_FULL) ? DS_OPEN : DS_OPENING;
        end else if (w_close_step) begin
            w_stroke_nxt = r_stroke - SW'(1);
            w_state_nxt  = (r_stroke == SW'(1)) ? DS_CLOSED : DS_CLOSING;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= DS_CLOSED;
            r_stroke <= '0;
            r_closed <= 1'b1;
            r_open   <= 1'b0;
            r_sensor <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_stroke <= w_stroke_nxt;
            r_closed <= (w_state_nxt == DS_CLOSED);
            r_open   <= (w_state_nxt == DS_OPEN);
            r_sensor <= w_sensor_nxt;
        end
    end

    assign o_closed = r_closed;
    assign o_open   = r_open;
    assign o_sensor = r_sensor;

endmodule

// File: rtl/elevator_shaft_model.sv
// Elevator cab/shaft/door plant answering a controller's actuator commands.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   engine, door       actuator commands (see package encodings)
//   obstruct           doorway obstruction injection
//   sensor_up/down     one-cycle floor-arrival pulses by direction
//   sensor_door        door obstruction sensor
//   door_closed/open   door end-stop sensors
//   at_floor           cab aligned with a floor
//   cab_floor          last floor reached
//   fault, fault_code  sticky fault flag and first cause
module elevator_shaft_model
    import elevator_shaft_model_pkg::*;
#(
    parameter int unsigned FLOORS          = 8,
    parameter int unsigned FLOOR_W         = 3,
    parameter int unsigned TICKS_PER_FLOOR = 4,
    parameter int unsigned DOOR_TICKS      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         engine,
    input  logic [1:0]         door,
    input  logic               obstruct,
    output logic               sensor_up,
    output logic               sensor_down,
    output logic               sensor_door,
    output logic               door_closed,
    output logic               door_open,
    output logic               at_floor,
    output logic [FLOOR_W-1:0] cab_floor,
    output logic               fault,
    output logic [2:0]         fault_code
);

    localparam int unsigned TICK_W = $clog2(TICKS_PER_FLOOR);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS - 1);
    localparam logic [TICK_W-1:0]  LAST_TICK = TICK_W'(TICKS_PER_FLOOR - 1);

    // Position held as (segment, tick): pos = r_seg*TICKS_PER_FLOOR + r_tick,
    // which avoids a modulo/divide on the position counter.
    logic [FLOOR_W-1:0] r_seg;
    logic [TICK_W-1:0]  r_tick;
    logic [FLOOR_W-1:0] r_cab_floor;
    logic               r_at_floor;
    logic               r_sensor_up;
    logic               r_sensor_down;
    logic               r_fault;
    logic [2:0]         r_fault_code;

    engine_cmd_e        w_eng;
    door_cmd_e          w_door_raw;
    door_cmd_e          w_door_eff;
    door_cmd_e          w_door_cmd;
    logic               w_door_closed;
    logic               w_at_top;
    logic               w_at_bottom;
    logic               w_move_up;
    logic               w_move_dn;
    logic               w_f_move_door;
    logic               w_f_overtravel;
    logic               w_f_door_moving;
    logic               w_f_illegal;
    logic [2:0]         w_fcode;
    logic [FLOOR_W-1:0] w_seg_nxt;
    logic [TICK_W-1:0]  w_tick_nxt;
    logic [FLOOR_W-1:0] w_cab_nxt;
    logic               w_land_up;
    logic               w_land_dn;

    always_comb begin
        w_eng      = (engine_cmd_e'(engine) == ENG_ILL) ? ENG_STOP : engine_cmd_e'(engine);
        w_door_raw = door_cmd_e'(door);
        w_door_eff = (w_door_raw == DOOR_ILL) ? DOOR_HOLD : w_door_raw;

        w_at_top    = (r_seg == TOP_FLOOR) && (r_tick == '0);
        w_at_bottom = (r_seg == '0) && (r_tick == '0);

        w_f_illegal     = (engine == 2'b11) || (door == 2'b11);
        w_f_move_door   = (w_eng != ENG_STOP) && !w_door_closed;
        w_f_overtravel  = (w_eng == ENG_UP && w_at_top) || (w_eng == ENG_DOWN && w_at_bottom);
        w_f_door_moving = (w_door_eff == DOOR_OPEN) && ((w_eng != ENG_STOP) || !r_at_floor);
        w_fcode = first_fault(w_f_move_door, w_f_overtravel, w_f_door_moving, w_f_illegal);

        w_door_cmd = w_f_door_moving ? DOOR_HOLD : w_door_eff;

        w_move_up = (w_eng == ENG_UP)   && w_door_closed && !w_at_top;
        w_move_dn = (w_eng == ENG_DOWN) && w_door_closed && !w_at_bottom;

        w_seg_nxt  = r_seg;
        w_tick_nxt = r_tick;
        w_cab_nxt  = r_cab_floor;
        w_land_up  = 1'b0;
        w_land_dn  = 1'b0;
        if (w_move_up) begin
            if (r_tick == LAST_TICK) begin
                w_seg_nxt  = r_seg + 1'b1;
                w_tick_nxt = '0;
                w_cab_nxt  = r_seg + 1'b1;
                w_land_up  = 1'b1;
            end else begin
                w_tick_nxt = r_tick + 1'b1;
            end
        end else if (w_move_dn) begin
            if (r_tick == '0) begin
                w_seg_nxt  = r_seg - 1'b1;
                w_tick_nxt = LAST_TICK;
            end else begin
                w_tick_nxt = r_tick - 1'b1;
                if (r_tick == TICK_W'(1)) begin
                    w_cab_nxt = r_seg;
                    w_land_dn = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg         <= '0;
            r_tick        <= '0;
            r_cab_floor   <= '0;
            r_at_floor    <= 1'b1;
            r_sensor_up   <= 1'b0;
            r_sensor_down <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_code  <= FLT_NONE;
        end else begin
            r_seg         <= w_seg_nxt;
            r_tick        <= w_tick_nxt;
            r_cab_floor   <= w_cab_nxt;
            r_at_floor    <= (w_tick_nxt == '0);
            r_sensor_up   <= w_land_up;
            r_sensor_down <= w_land_dn;
            if (!r_fault && w_fcode != FLT_NONE) begin
                r_fault      <= 1'b1;
                r_fault_code <= w_fcode;
            end
        end
    end

    elevator_door_model #(
        .DOOR_TICKS (DOOR_TICKS)
    ) u_door (
        .clk        (clk),
        .rst        (reset),
        .i_cmd      (w_door_cmd),
        .i_obstruct (obstruct),
        .o_closed   (w_door_closed),
        .o_open     (door_open),
        .o_sensor   (sensor_door)
    );

    assign door_closed = w_door_closed;
    assign sensor_up   = r_sensor_up;
    assign sensor_down = r_sensor_down;
    assign at_floor    = r_at_floor;
    assign cab_floor   = r_cab_floor;
    assign fault       = r_fault;
    assign fault_code  = r_fault_code;

endmodule
